// File: rtl/arb_pkg.sv
//==============================================================================
// Module      : arb_pkg
// Description : Shared constants, state type and round-robin pick function
//               for the mux4_rr_arbiter block.
// Contents    : NUM_REQ, SEL_W, arb_state_t, rr_pick_t, rr_pick()
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } rr_pick_t;

    // Scan ptr, ptr+1, ... (mod NUM_REQ) and return the first requester.
    function automatic rr_pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                         input logic [SEL_W-1:0]   ptr);
        rr_pick_t         res;
        logic [SEL_W-1:0] cand;
        res = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ptr + SEL_W'(i);
            if (!res.found && req[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/four_to_one_mux.sv
//==============================================================================
// Module      : four_to_one_mux
// Description : Single-bit 4:1 multiplexer, one per data bit slice.
// Ports       : x   [3:0] - input bits, x[i] is lane i
//               sel [1:0] - lane select
//               Q         - selected bit
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module four_to_one_mux (
    input  logic [3:0] x,
    input  logic [1:0] sel,
    output logic       Q
);

    always_comb begin
        Q = 1'b0;
        case (sel)
            2'd0:    Q = x[0];
            2'd1:    Q = x[1];
            2'd2:    Q = x[2];
            default: Q = x[3];
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
//==============================================================================
// Module      : mux4_rr_arbiter
// Description : Round-robin arbiter sequencing a shared 4:1 mux datapath.
//               Registers a one-hot grant, drives the mux select from the
//               granted index and flags when Q carries a granted lane.
// Parameters  : DATA_W   - width of each lane
//               MAX_HOLD - max consecutive grant cycles before rotation
// Macro       : ARB_TIMEOUT_EN - when defined, a holder at MAX_HOLD cycles is
//               forced to release if any other requester is waiting.
// Ports       : clk, rst_n (async active-low)
//               req   [3:0]        - level-sensitive requests
//               x     [4*DATA_W-1:0] - data lanes, lane i = x[i*DATA_W +: DATA_W]
//               grant [3:0]        - registered one-hot grant (0 when idle)
//               sel   [1:0]        - registered mux select
//               valid              - registered, high while a grant is active
//               Q     [DATA_W-1:0] - combinational lane x[sel]
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mux4_rr_arbiter
    import arb_pkg::*;
#(
    parameter int DATA_W   = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*DATA_W-1:0] x,
    output logic [NUM_REQ-1:0]      grant,
    output logic [SEL_W-1:0]        sel,
    output logic                    valid,
    output logic [DATA_W-1:0]       Q
);

    arb_state_t         state, state_nxt;
    logic [SEL_W-1:0]   ptr, ptr_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [SEL_W-1:0]   sel_nxt;
    logic               valid_nxt;
    logic               owner_req;
    logic               forced;
    logic [SEL_W-1:0]   next_ptr;
    rr_pick_t           pick;

    // While granted, sel always names the owner.
    assign owner_req = req[sel];
    assign next_ptr  = sel + SEL_W'(1);

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    logic [HOLD_W-1:0] hold_cnt, hold_nxt;

    // Rotation is only forced when someone else is actually waiting.
    assign forced = (hold_cnt == HOLD_MAX) && owner_req && |(req & ~grant);
`else
    logic unused_max_hold;
    assign unused_max_hold = (MAX_HOLD != 0);
    assign forced          = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        grant_nxt = grant;
        sel_nxt   = sel;
        valid_nxt = valid;
        pick      = '0;
`ifdef ARB_TIMEOUT_EN
        hold_nxt  = hold_cnt;
`endif
        case (state)
            ARB_IDLE: begin
                pick = rr_pick(req, ptr);
                if (pick.found) begin
                    state_nxt = ARB_GRANT;
                    grant_nxt = NUM_REQ'(1) << pick.idx;
                    sel_nxt   = pick.idx;
                    valid_nxt = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_nxt  = HOLD_W'(1);
`endif
                end else begin
                    grant_nxt = '0;
                    valid_nxt = 1'b0;
                end
            end
            default: begin
                if (!owner_req || forced) begin
                    // Owner is masked so a forced release never re-picks it;
                    // on a plain release its req bit is already low.
                    ptr_nxt = next_ptr;
                    pick    = rr_pick(req & ~grant, next_ptr);
                    if (pick.found) begin
                        grant_nxt = NUM_REQ'(1) << pick.idx;
                        sel_nxt   = pick.idx;
                        valid_nxt = 1'b1;
`ifdef ARB_TIMEOUT_EN
                        hold_nxt  = HOLD_W'(1);
`endif
                    end else begin
                        state_nxt = ARB_IDLE;
                        grant_nxt = '0;
                        valid_nxt = 1'b0;
`ifdef ARB_TIMEOUT_EN
                        hold_nxt  = '0;
`endif
                    end
                end else begin
`ifdef ARB_TIMEOUT_EN
                    if (hold_cnt != HOLD_MAX) begin
                        hold_nxt = hold_cnt + HOLD_W'(1);
                    end
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            ptr      <= '0;
            grant    <= '0;
            sel      <= '0;
            valid    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            grant    <= grant_nxt;
            sel      <= sel_nxt;
            valid    <= valid_nxt;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= hold_nxt;
`endif
        end
    end

    // One 4:1 mux per bit slice, all steered by the registered select.
    for (genvar b = 0; b < DATA_W; b++) begin : g_bit
        four_to_one_mux u_mux (
            .x   ({x[3*DATA_W+b], x[2*DATA_W+b], x[DATA_W+b], x[b]}),
            .sel (sel),
            .Q   (Q[b])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
//==============================================================================
// Module      : tb_mux4_rr_arbiter
// Description : Directed self-checking bench for mux4_rr_arbiter
//               (DATA_W=1, MAX_HOLD=4). Honours ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] x;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
    logic [0:0] Q;

    int n_cmp;
    int n_err;

    mux4_rr_arbiter #(
        .DATA_W   (1),
        .MAX_HOLD (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .x     (x),
        .grant (grant),
        .sel   (sel),
        .valid (valid),
        .Q     (Q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_g;
        n_cmp = 0;
        n_err = 0;

        // ---- 1. reset with all requesting ----
        rst_n = 1'b0;
        req   = 4'b1111;
        x     = 4'b0101;
        step();
        step();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_sel",   32'(sel),   32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_Q",     32'(Q),     32'h1);
        rst_n = 1'b1;
        step();
        chk("rel_grant", 32'(grant), 32'h1);
        chk("rel_sel",   32'(sel),   32'h0);
        chk("rel_valid", 32'(valid), 32'h1);

        // owner 0 drops with nothing pending -> idle, ptr=1
        req = 4'b0000;
        step();
        chk("idle_grant", 32'(grant), 32'h0);
        chk("idle_valid", 32'(valid), 32'h0);
        chk("idle_sel",   32'(sel),   32'h0);

        // ---- 2. single requester 2 ----
        req = 4'b0100;
        step();
        chk("single_grant", 32'(grant), 32'h4);
        chk("single_sel",   32'(sel),   32'h2);
        chk("single_Q",     32'(Q),     32'h1);
        chk("single_valid", 32'(valid), 32'h1);
        req = 4'b0000;
        step();
        chk("drop_grant", 32'(grant), 32'h0);
        chk("drop_valid", 32'(valid), 32'h0);
        chk("drop_sel",   32'(sel),   32'h2);
        x = 4'b0001;
        #1;
        chk("idle_Q_follows_x2", 32'(Q), 32'h0);

        // ---- 3. rotate on release (ptr=3 now, so 0010 picks index 1) ----
        req = 4'b0010;
        step();
        chk("own1_grant", 32'(grant), 32'h2);
        req = 4'b1111;
        step();
        chk("own1_hold", 32'(grant), 32'h2);
        req = 4'b1101;
        step();
        chk("rr_grant", 32'(grant), 32'h4);
        chk("rr_sel",   32'(sel),   32'h2);

        // ---- 4. all requesting from a fresh reset ----
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        req = 4'b1111;
        for (int k = 0; k < 17; k++) begin
            step();
`ifdef ARB_TIMEOUT_EN
            exp_g = 4'b0001 << ((k / 4) % 4);
`else
            exp_g = 4'b0001;
`endif
            chk($sformatf("all_req_c%0d", k), 32'(grant), 32'(exp_g));
        end

        // ---- 5. sole requester 3 well past MAX_HOLD ----
        req = 4'b1000;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("sole_grant_c%0d", k), 32'(grant), 32'h8);
            chk($sformatf("sole_valid_c%0d", k), 32'(valid), 32'h1);
        end

        // ---- 6. async reset mid-grant ----
        // owner 3 drops -> ptr=0, scan reaches 2
        req = 4'b0100;
        step();
        chk("pre_arst_grant", 32'(grant), 32'h4);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_grant", 32'(grant), 32'h0);
        chk("arst_valid", 32'(valid), 32'h0);
        chk("arst_sel",   32'(sel),   32'h0);
        req = 4'b0110;
        #1;
        rst_n = 1'b1;
        step();
        chk("post_arst_grant", 32'(grant), 32'h2);
        chk("post_arst_sel",   32'(sel),   32'h1);
        chk("post_arst_valid", 32'(valid), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter sharing one four_to_one_mux datapath among four requesters. Each requester i owns input lane x[i] and asserts req[i] to have its lane routed to Q. The block registers a one-hot grant, drives the mux select from the granted index and flags when Q carries a granted lane. It sits in front of the existing 4:1 mux as its sequencing controller.

Parameters:
DATA_W, 1, width of each mux lane; x is 4*DATA_W bits, lane i = x[i*DATA_W +: DATA_W]
MAX_HOLD, 4, maximum consecutive grant cycles before forced rotation (>=1; used only with ARB_TIMEOUT_EN)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  4  request per requester, level-sensitive
x  input  4*DATA_W  mux data lanes
grant  output  4  registered one-hot grant, 0000 when idle
sel  output  2  registered mux select, index of current or last grantee
valid  output  1  registered; 1 while a grant is active
Q  output  DATA_W  combinational mux output, x lane indexed by sel

Behaviour:
- Reset is asynchronous: on rst_n=0, outputs go immediately to grant=0000, sel=00, valid=0, state=IDLE, ptr=0, hold_cnt=0. Q follows x[0] during reset.
- The FSM has two states, IDLE and GRANT. ptr (2 bits) is the highest-priority index for the next arbitration.
- Winner selection: the first i with req[i]=1, scanning ptr, ptr+1, ... mod 4.
- IDLE with any req: at the next edge, grant=onehot(winner), sel=winner, valid=1, hold_cnt=1, and the FSM moves to GRANT. Latency from req to grant is 1 clock.
- IDLE with req=0000: the block stays in IDLE. sel holds its last value and valid=0.
- GRANT while req[owner]=1 and no forced release: the grant holds and hold_cnt increments, saturating at MAX_HOLD.
- GRANT while req[owner]=0 (release):
  - ptr becomes owner+1 mod 4.
  - If other requests are pending, the winner is granted at the same edge with no idle bubble and hold_cnt=1.
  - If none are pending, the FSM goes to IDLE with grant=0000 and valid=0.
- Forced release happens when hold_cnt==MAX_HOLD, req[owner]=1 and any other req bit is set. The block then rotates exactly as on release, excluding the owner from that edge's scan.
- A sole requester at MAX_HOLD keeps its grant. hold_cnt stays at MAX_HOLD and nothing toggles.
- hold_cnt width is $clog2(MAX_HOLD+1). It never wraps.
- Q = lane x[sel] in all states, so consumers must qualify Q with valid.
- Reset asserted mid-grant clears everything immediately. The first grant after release of rst_n goes to requester 0 if it is requesting.

Optional Feature:
ARB_TIMEOUT_EN
- Defined: forced release at MAX_HOLD, as described in Behaviour.
- Undefined: the hold_cnt logic is removed and a grant is held until req[owner] drops, regardless of other requests. MAX_HOLD is ignored.

Decomposition:
- Package arb_pkg holds:
  - NUM_REQ=4 and SEL_W=2
  - the state typedef arb_state_t {ARB_IDLE, ARB_GRANT}
  - the function rr_pick(req, ptr), returning a valid flag and an index
- Sub-module: the existing four_to_one_mux, instantiated DATA_W times via generate, one per bit slice, with sel driven from the arbiter.

Test Plan:
1. Reset: hold rst_n=0 with req=1111, then release. Expect grant=0000, sel=00, valid=0 during reset. At the first edge after release: grant=0001, sel=00, valid=1.
2. Single requester: req=0100, x=0101, DATA_W=1. Expect one edge later grant=0100, sel=10, Q=1, valid=1. Then req=0000: next edge grant=0000, valid=0, sel stays 10.
3. Round robin on release: owner=1 (grant=0010), req changes from 1111 to 1101. Expect next edge grant=0100 (index 2), not 0001.
4. Timeout (macro defined, MAX_HOLD=4): req=1111 held. Expect grant 0001 for 4 cycles, then 0010 ×4, 0100 ×4, 1000 ×4, then 0001.
   - With the macro undefined: grant=0001 forever.
5. Sole requester past MAX_HOLD: req=1000 for 10 cycles. Expect grant=1000 steady, valid=1, with no toggling.
6. Async reset mid-grant: rst_n=0 between edges while grant=0100. Expect grant=0000 and valid=0 immediately, without waiting for an edge. After release with req=0110: grant=0010.
